addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 114 +++++++++++
 tb/tb_addsub_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end to one shared ripple add/sub unit.
// Latency: the result is valid two cycles after the ready pulse. A new op can issue every 3 cycles at best.
// Backpressure: a result is held stable until res_ready. No request is accepted outside IDLE.
module addsub_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_sub,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_sub,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [W-1:0] res_out,
    output logic         res_cout,
    output logic         res_ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t         state;
    logic           prio;
    logic           op_sub;
    logic           op_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

    logic           gnt0;
    logic           gnt1;
    logic [W-1:0]   b_x;
    logic [W-1:0]   sum;
    logic [W:0]     carry;
    logic           ovf;

    // A lone requester always wins. A tie goes to the requester that prio points at.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || !prio);
        gnt1 = req1_valid && (!req0_valid ||  prio);
    end

    // Ready is gated by rst_n so that it reads low for the whole time reset is held.
    assign req0_ready = rst_n && (state == IDLE) && gnt0;
    assign req1_ready = rst_n && (state == IDLE) && gnt1;

    assign b_x      = op_b ^ {W{op_sub}};
    assign carry[0] = op_sub;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]     = op_a[i] ^ b_x[i] ^ carry[i];
        assign carry[i+1] = (op_a[i] & b_x[i]) | (carry[i] & (op_a[i] ^ b_x[i]));
    end

    assign ovf = (op_a[W-1] == b_x[W-1]) && (sum[W-1] != op_a[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            op_sub    <= 1'b0;
            op_id     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_out   <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_sub <= gnt1 ? req1_sub : req0_sub;
                        op_a   <= gnt1 ? req1_a   : req0_a;
                        op_b   <= gnt1 ? req1_b   : req0_b;
                        op_id  <= gnt1;
                        prio   <= gnt0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_out   <= sum;
                    res_cout  <= carry[W];
                    res_ovf   <= ovf;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (W=4): single ops, backpressure, reset mid-op, round-robin.
module tb_addsub_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_id, res_cout, res_ovf;
    logic [W-1:0] res_out;

    int n_checks = 0;
    int n_fails  = 0;

    addsub_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_out(res_out), .res_cout(res_cout), .res_ovf(res_ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with res_ready high, starting and ending in IDLE.
    task automatic do_op(input logic id, input logic sub, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] e_out, input logic e_cout, input logic e_ovf);
        if (id) begin
            req1_valid = 1'b1; req1_sub = sub; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_sub = sub; req0_a = a; req0_b = b;
        end
        #1;
        chk("grant_ready", id ? req1_ready : req0_ready, 1'b1);
        chk("other_ready", id ? req0_ready : req1_ready, 1'b0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        req0_sub = ~sub; req1_sub = ~sub;
        #1;
        chk("exec_valid", res_valid, 1'b0);
        chk("exec_ready", req0_ready | req1_ready, 1'b0);
        step();
        chk("res_valid", res_valid, 1'b1);
        chk("res_out", res_out, e_out);
        chk("res_cout", res_cout, e_cout);
        chk("res_ovf", res_ovf, e_ovf);
        chk("res_id", res_id, id);
        step();
        chk("idle_valid", res_valid, 1'b0);
        chk("hold_out", res_out, e_out);
    endtask

    initial begin
        logic       exp_id;
        logic [3:0] exp_out;

        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
        #2;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_out", res_out, 4'd0);
        chk("rst_cout", res_cout, 1'b0);
        chk("rst_ovf", res_ovf, 1'b0);
        chk("rst_id", res_id, 1'b0);
        step();
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        step();

        do_op(1'b0, 1'b0, 4'd3,  4'd4, 4'd7,  1'b0, 1'b0);
        do_op(1'b1, 1'b1, 4'd2,  4'd5, 4'd13, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, 4'd7,  4'd8, 4'd15, 1'b0, 1'b1);
        do_op(1'b0, 1'b0, 4'd15, 4'd1, 4'd0,  1'b1, 1'b0);
        do_op(1'b0, 1'b0, 4'd7,  4'd1, 4'd8,  1'b0, 1'b1);
        do_op(1'b1, 1'b0, 4'd8,  4'd8, 4'd0,  1'b1, 1'b1);
        do_op(1'b0, 1'b1, 4'd0,  4'd0, 4'd0,  1'b1, 1'b0);
        do_op(1'b1, 1'b1, 4'd8,  4'd1, 4'd7,  1'b1, 1'b1);
        do_op(1'b0, 1'b1, 4'd5,  4'd5, 4'd0,  1'b1, 1'b0);

        // Backpressure: hold the result, keep both requesters asking and wiggling.
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 4'd6; req0_b = 4'd3;
        #1;
        chk("bp_grant", req0_ready, 1'b1);
        step();
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_out", res_out, 4'd9);
            chk("bp_ovf", res_ovf, 1'b1);
            chk("bp_cout", res_cout, 1'b0);
            chk("bp_id", res_id, 1'b0);
            chk("bp_ready", req0_ready | req1_ready, 1'b0);
            req0_a = 4'(i); req0_sub = ~req0_sub;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk("bp_release", res_valid, 1'b0);

        // Reset in the middle of EXEC throws the op away.
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 4'd9; req1_b = 4'd3;
        #1;
        chk("rx_grant", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rx_valid", res_valid, 1'b0);
        chk("rx_out", res_out, 4'd0);
        chk("rx_ovf", res_ovf, 1'b0);
        chk("rx_cout", res_cout, 1'b0);
        chk("rx_id", res_id, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rx_no_result", res_valid, 1'b0);
        end

        // Both valid throughout: grants alternate and start with requester 0.
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 4'd9; req1_b = 4'd3;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_id  = (k % 2 == 1);
            exp_out = exp_id ? 4'd6 : 4'd3;
            chk("rr_ready0", req0_ready, !exp_id);
            chk("rr_ready1", req1_ready, exp_id);
            step();
            chk("rr_exec_ready", req0_ready | req1_ready, 1'b0);
            step();
            chk("rr_valid", res_valid, 1'b1);
            chk("rr_id", res_id, exp_id);
            chk("rr_out", res_out, exp_out);
            chk("rr_ovf", res_ovf, exp_id);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
